rom_arbiter: RTL
================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter: DEPTH, default 10, number of valid ROM words (addresses 0..DEPTH-1).
REQ-002 Parameter: N_REQ, fixed 2, number of requesters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  2  per-requester read request, level, held until own rvalid.
REQ-006 addr0  input  4  requester 0 read address, stable while req[0] high.
REQ-007 addr1  input  4  requester 1 read address, stable while req[1] high.
REQ-008 gnt  output  2  one-hot owner of the ROM, high during FETCH and RESP.
REQ-009 rvalid  output  2  one-cycle pulse to owner when rdata is valid.
REQ-010 rdata  output  8  read data, shared by both requesters.
REQ-011 oob  output  1  out-of-bounds flag, qualified by rvalid.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, FETCH, RESP.
REQ-013 In IDLE, when any req bit is high, the block SHALL pick one requester, latch its address, set gnt one-hot and go to FETCH.
REQ-014 In IDLE with req==0, the block SHALL remain in IDLE with gnt==0.
REQ-015 Arbitration SHALL be round-robin: on simultaneous req==2'b11, grant the requester not served last.
REQ-016 After reset the round-robin pointer SHALL favour requester 0.
REQ-017 In FETCH, the block SHALL drive the latched address to the internal ROM and register its data into rdata, then go to RESP.
REQ-018 If the latched address >= DEPTH, FETCH SHALL load rdata=8'h00 and set oob=1 instead of using ROM data.
REQ-019 In RESP, rvalid[owner] SHALL be 1 for exactly one cycle, the pointer SHALL record owner, and the next state SHALL be IDLE.
REQ-020 Latency: req high in IDLE cycle 0 -> gnt high cycles 1-2 -> rvalid and rdata valid in cycle 2.
REQ-021 Throughput: at most one grant per 3 cycles, back-to-back grants alternate when both requesters stay high.
REQ-022 req SHALL be sampled only in IDLE; changes in FETCH/RESP are ignored.
REQ-023 addr0/addr1 changes after the IDLE latch SHALL NOT affect the in-flight read.
REQ-024 A requester still high in the cycle after its rvalid SHALL be treated as a new request.
REQ-025 rdata and oob SHALL hold their last values until the next FETCH.
REQ-026 gnt and rvalid SHALL never have more than one bit set.

Reset
REQ-027 On rst==1 at a clock edge: state=IDLE, gnt=0, rvalid=0, rdata=0, oob=0, pointer favours requester 0.
REQ-028 Reset during FETCH or RESP SHALL abort the read with no rvalid pulse emitted.
REQ-029 rst SHALL take priority over all other inputs in the same cycle.

Structure
REQ-030 Package rom_arb_pkg SHALL hold ADDR_W=4, DATA_W=8, ROM_DEPTH=10 and the FSM state enum.
REQ-031 The block SHALL instantiate the existing rom module (4-bit address in, 8-bit data out) as its single sub-module.
REQ-032 No other sub-modules are required; arbitration logic stays inline.

Verification
REQ-033 Single req[0]=1, addr0=3 in IDLE -> gnt=01 cycles 1-2, rvalid=01 in cycle 2, rdata=ROM[3], oob=0.
REQ-034 req=11 from reset, addr0=1, addr1=5, held -> grants order 0,1,0; rvalid 01 (cycle 2), 10 (cycle 5), 01 (cycle 8).
REQ-035 req[1]=1, addr1=4'hA -> rvalid=10 in cycle 2, rdata=00, oob=1; next access with addr1=9 -> rdata=ROM[9], oob=0.
REQ-036 rst pulsed in FETCH cycle of a read -> no rvalid, gnt=00, rdata=00 next cycle, next req[1]=1 still yields correct data.
REQ-037 addr0 changed 3->7 in FETCH cycle -> rdata=ROM[3].
REQ-038 Sweep addr0 0..15 sequentially -> rdata matches ROM for 0..9, rdata=00 with oob=1 for 10..15.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared widths, ROM depth and FSM state encoding for rom_arbiter
package rom_arb_pkg;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int ROM_DEPTH = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/rom.sv
// rtl/rom.sv - asynchronous-read constant ROM, 4-bit address, 8-bit data
module rom
  import rom_arb_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Words past the populated range read as all-ones; callers mask them.
  always_comb begin
    data = 8'hFF;
    case (addr)
      4'd0: data = 8'h3C;
      4'd1: data = 8'hA5;
      4'd2: data = 8'h5A;
      4'd3: data = 8'h7E;
      4'd4: data = 8'h01;
      4'd5: data = 8'hC3;
      4'd6: data = 8'h99;
      4'd7: data = 8'h42;
      4'd8: data = 8'hF0;
      4'd9: data = 8'h0F;
      default: data = 8'hFF;
    endcase
  end

endmodule

// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - two-requester round-robin arbiter in front of a shared ROM
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int DEPTH = ROM_DEPTH,
  parameter int N_REQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic [N_REQ-1:0]  gnt,
  output logic [N_REQ-1:0]  rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              oob
);

  state_t              state, state_nxt;
  logic                owner, owner_nxt;
  logic                last;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic [DATA_W-1:0]   rom_data;
  logic                addr_oob;
  logic [N_REQ-1:0]    owner_oh;

  rom u_rom (
    .addr (addr_q),
    .data (rom_data)
  );

  assign addr_oob = int'(addr_q) >= DEPTH;
  assign owner_oh = owner ? 2'b10 : 2'b01;

  // Requests are only looked at in IDLE; the owner and its address are frozen
  // for the FETCH/RESP pair so late addr changes cannot disturb the read.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    addr_nxt  = addr_q;
    gnt       = '0;
    rvalid    = '0;
    case (state)
      IDLE: begin
        if (req != '0) begin
          owner_nxt = (req == 2'b11) ? ~last : req[1];
          addr_nxt  = owner_nxt ? addr1 : addr0;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        gnt       = owner_oh;
        state_nxt = RESP;
      end
      RESP: begin
        gnt       = owner_oh;
        rvalid    = owner_oh;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      addr_q <= '0;
      rdata  <= '0;
      oob    <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      addr_q <= addr_nxt;
      if (state == FETCH) begin
        rdata <= addr_oob ? '0 : rom_data;
        oob   <= addr_oob;
      end
      // "last" starts at 1 so the first contested grant goes to requester 0.
      if (state == RESP) begin
        last <= owner;
      end
    end
  end

endmodule
